// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM serving an instruction fetch port
// and a load/store port, each with its own req/resp handshake FSM.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   PC                   fetch byte address
//   Inst_Req_Valid/Ready fetch request handshake
//   Instruction          fetched word, held while Inst_Valid
//   Inst_Valid/Ready     fetch response handshake
//   Address              load/store byte address
//   MemWrite/MemRead     store / load request
//   Write_data/strb      store data and byte enables
//   Mem_Req_Ready        data request accepted
//   Read_data            loaded word, held while Read_data_Valid
//   Read_data_Valid/Rdy  load response handshake
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] DLY = 4'(RESP_DELAY);

  typedef logic [ADDR_WIDTH-1:0] idx_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_WAIT,
    I_RESP
  } i_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_RESP
  } d_state_t;

  i_state_t    i_state;
  i_state_t    i_next;
  d_state_t    d_state;
  d_state_t    d_next;
  logic [3:0]  i_cnt;
  logic [3:0]  i_cnt_nx;
  logic [3:0]  d_cnt;
  logic [3:0]  d_cnt_nx;
  idx_t        i_idx;
  idx_t        i_idx_nx;
  idx_t        d_idx;
  idx_t        d_idx_nx;
  idx_t        a_idx;
  idx_t        pc_idx;
  idx_t        ram_addr;
  logic [31:0] ram_rdata;
  logic        wr_en;
  logic        d_rd_en;
  logic        i_rd_en;
  logic        unused_bits;

  logic [31:0] mem [DEPTH];

  assign a_idx  = Address[ADDR_WIDTH+1:2];
  assign pc_idx = PC[ADDR_WIDTH+1:2];

  // Byte offset and bits above the RAM depth wrap away.
  assign unused_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0],
                         PC[31:ADDR_WIDTH+2], PC[1:0]};

  assign Inst_Req_Ready  = (i_state == I_IDLE);
  assign Inst_Valid      = (i_state == I_RESP);
  assign Mem_Req_Ready   = (d_state == D_IDLE);
  assign Read_data_Valid = (d_state == D_RESP);

  // One RAM port: store beats load beats fetch.
  // A fetch that loses keeps its zero count and retries.
  assign wr_en   = !rst && (d_state == D_IDLE) && MemWrite;
  assign d_rd_en = (d_state == D_WAIT) && (d_cnt == 4'd0);
  assign i_rd_en = (i_state == I_WAIT) && (i_cnt == 4'd0) &&
                   !wr_en && !d_rd_en;

  always_comb begin
    ram_addr = i_idx;
    unique case (1'b1)
      wr_en:   ram_addr = a_idx;
      d_rd_en: ram_addr = d_idx;
      default: ram_addr = i_idx;
    endcase
  end

  assign ram_rdata = mem[ram_addr];

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          mem[ram_addr][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
  end

  // Instruction FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state <= I_IDLE;
      i_cnt   <= 4'd0;
      i_idx   <= '0;
    end else begin
      i_state <= i_next;
      i_cnt   <= i_cnt_nx;
      i_idx   <= i_idx_nx;
    end
  end

  always_comb begin
    i_next   = i_state;
    i_cnt_nx = i_cnt;
    i_idx_nx = i_idx;
    unique case (i_state)
      I_IDLE: begin
        if (Inst_Req_Valid) begin
          i_next   = I_WAIT;
          i_cnt_nx = DLY;
          i_idx_nx = pc_idx;
        end
      end
      I_WAIT: begin
        if (i_cnt != 4'd0) begin
          i_cnt_nx = i_cnt - 4'd1;
        end else if (i_rd_en) begin
          i_next = I_RESP;
        end
      end
      I_RESP: begin
        if (Inst_Ready) begin
          i_next = I_IDLE;
        end
      end
      default: i_next = I_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Instruction <= 32'd0;
    end else if (i_rd_en) begin
      Instruction <= ram_rdata;
    end
  end

  // Data FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state <= D_IDLE;
      d_cnt   <= 4'd0;
      d_idx   <= '0;
    end else begin
      d_state <= d_next;
      d_cnt   <= d_cnt_nx;
      d_idx   <= d_idx_nx;
    end
  end

  always_comb begin
    d_next   = d_state;
    d_cnt_nx = d_cnt;
    d_idx_nx = d_idx;
    unique case (d_state)
      D_IDLE: begin
        // A store with a load set too is a store only.
        if (MemRead && !MemWrite) begin
          d_next   = D_WAIT;
          d_cnt_nx = DLY;
          d_idx_nx = a_idx;
        end
      end
      D_WAIT: begin
        if (d_cnt != 4'd0) begin
          d_cnt_nx = d_cnt - 4'd1;
        end else begin
          d_next = D_RESP;
        end
      end
      D_RESP: begin
        if (Read_data_Ready) begin
          d_next = D_IDLE;
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Read_data <= 32'd0;
    end else if (d_rd_en) begin
      Read_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder.
// Expected words come from a flat word-array model of the RAM.
module tb_mem_responder;

  localparam int AW   = 10;
  localparam int DLY  = 2;
  localparam int BASE = 2 + DLY;

  typedef struct {
    logic [31:0] data;
    int          t_acc;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  logic [31:0] model [0:(1<<AW)-1];
  exp_t        iq[$];
  exp_t        dq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_i_first = 0;
  int          last_d_first = 0;
  bit          rand_rdy = 0;
  logic        irdy_dir = 1'b1;
  logic        drdy_dir = 1'b1;

  mem_responder #(
    .ADDR_WIDTH(AW),
    .RESP_DELAY(DLY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .Inst_Req_Valid (Inst_Req_Valid),
    .Inst_Req_Ready (Inst_Req_Ready),
    .Instruction    (Instruction),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .Address        (Address),
    .MemWrite       (MemWrite),
    .Write_data     (Write_data),
    .Write_strb     (Write_strb),
    .MemRead        (MemRead),
    .Mem_Req_Ready  (Mem_Req_Ready),
    .Read_data      (Read_data),
    .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    Inst_Ready      = 1'b1;
    Read_data_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      Inst_Ready      = rand_rdy ? 1'($urandom_range(0, 1)) : irdy_dir;
      Read_data_Ready = rand_rdy ? 1'($urandom_range(0, 1)) : drdy_dir;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input bit ok,
                       input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    bit          i_pv;
    bit          d_pv;
    logic [31:0] i_prev;
    logic [31:0] d_prev;
    int          i_first;
    int          d_first;
    exp_t        e;
    i_pv = 0;
    d_pv = 0;
    i_first = 0;
    d_first = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        i_pv = 0;
        d_pv = 0;
        continue;
      end
      if (Inst_Valid) begin
        if (!i_pv) begin
          i_first = cyc;
          last_i_first = cyc;
        end else begin
          check("inst_stable", Instruction === i_prev, Instruction, i_prev);
        end
        if (Inst_Ready) begin
          if (iq.size() == 0) begin
            check("inst_unexpected", 0, Instruction, 0);
          end else begin
            e = iq.pop_front();
            check("inst_data", Instruction === e.data, Instruction, e.data);
            if (e.lat >= 0)
              check("inst_latency", (i_first - e.t_acc) == e.lat,
                    i_first - e.t_acc, e.lat);
            else
              check("inst_latency_min", (i_first - e.t_acc) >= BASE,
                    i_first - e.t_acc, BASE);
          end
        end
        i_prev = Instruction;
      end
      i_pv = Inst_Valid && !Inst_Ready;
      if (Read_data_Valid) begin
        if (!d_pv) begin
          d_first = cyc;
          last_d_first = cyc;
        end else begin
          check("rd_stable", Read_data === d_prev, Read_data, d_prev);
        end
        if (Read_data_Ready) begin
          if (dq.size() == 0) begin
            check("rd_unexpected", 0, Read_data, 0);
          end else begin
            e = dq.pop_front();
            check("rd_data", Read_data === e.data, Read_data, e.data);
            check("rd_latency", (d_first - e.t_acc) == e.lat,
                  d_first - e.t_acc, e.lat);
          end
        end
        d_prev = Read_data;
      end
      d_pv = Read_data_Valid && !Read_data_Ready;
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic do_fetch(input logic [31:0] pc, input int lat);
    exp_t e;
    int   n;
    n = 0;
    PC = pc;
    Inst_Req_Valid = 1'b1;
    forever begin
      @(negedge clk);
      if (Inst_Req_Ready) break;
      if (++n > 200) begin
        check("fetch_accept_timeout", 0, n, 200);
        @(posedge clk);
        #1;
        Inst_Req_Valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    e.data  = model[pc[AW+1:2]];
    e.t_acc = cyc;
    e.lat   = lat;
    iq.push_back(e);
    @(posedge clk);
    #1;
    Inst_Req_Valid = 1'b0;
    PC = $urandom;
  endtask

  task automatic wait_data_accept(output bit ok);
    int n;
    n = 0;
    ok = 1;
    forever begin
      @(negedge clk);
      if (Mem_Req_Ready) break;
      if (++n > 200) begin
        check("data_accept_timeout", 0, n, 200);
        ok = 0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit also_read);
    bit          ok;
    logic [31:0] w;
    Address    = addr;
    Write_data = data;
    Write_strb = strb;
    MemWrite   = 1'b1;
    MemRead    = also_read;
    wait_data_accept(ok);
    if (ok) begin
      w = model[addr[AW+1:2]];
      for (int b = 0; b < 4; b++)
        if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      model[addr[AW+1:2]] = w;
    end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    bit   ok;
    exp_t e;
    Address    = addr;
    Write_data = $urandom;
    Write_strb = 4'($urandom_range(0, 15));
    MemWrite   = 1'b0;
    MemRead    = 1'b1;
    wait_data_accept(ok);
    if (ok) begin
      e.data  = model[addr[AW+1:2]];
      e.t_acc = cyc;
      e.lat   = BASE;
      dq.push_back(e);
    end
    @(posedge clk);
    #1;
    MemRead = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain", (iq.size() + dq.size()) == 0, iq.size() + dq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    PC             = '0;
    Inst_Req_Valid = 1'b0;
    Address        = '0;
    MemWrite       = 1'b0;
    Write_data     = '0;
    Write_strb     = '0;
    MemRead        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_inst_req_ready", Inst_Req_Ready === 1'b1, Inst_Req_Ready, 1);
    check("rst_mem_req_ready", Mem_Req_Ready === 1'b1, Mem_Req_Ready, 1);
    check("rst_inst_valid", Inst_Valid === 1'b0, Inst_Valid, 0);
    check("rst_rd_valid", Read_data_Valid === 1'b0, Read_data_Valid, 0);
    check("rst_instruction", Instruction === 32'd0, Instruction, 0);
    check("rst_read_data", Read_data === 32'd0, Read_data, 0);
    @(posedge clk);
    #1;

    // Store then fetch the same word
    do_write(32'h10, 32'hDEADBEEF, 4'b1111, 0);
    do_fetch(32'h10, BASE);
    drain();

    // Byte-lane store merges into an existing word
    do_write(32'h8, 32'h11223344, 4'b1111, 0);
    do_write(32'h9, 32'h55AA_AA66, 4'b0010, 0);
    do_read(32'h8);
    drain();
    check("merge_model", model[2] === 32'h1122AA44, model[2], 32'h1122AA44);

    // Empty strobe and store+load combos leave no response
    do_write(32'h8, 32'hFFFFFFFF, 4'b0000, 0);
    do_write(32'h20, 32'hCAFEF00D, 4'b1111, 1);
    repeat (8) @(posedge clk);
    #1;
    do_read(32'h8);
    do_read(32'h20);
    drain();

    // Fetch and load accepted together: load wins the RAM
    fork
      do_fetch(32'h10, BASE + 1);
      do_read(32'h8);
    join
    drain();
    check("contend_order", (last_i_first - last_d_first) == 1,
          last_i_first - last_d_first, 1);

    // Fetch response held by a stalled initiator
    irdy_dir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_fetch(32'h10, BASE);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Inst_Valid && n < 20);
    check("stall_valid_seen", Inst_Valid === 1'b1, Inst_Valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", Inst_Valid === 1'b1, Inst_Valid, 1);
      check("stall_instr", Instruction === model[4], Instruction, model[4]);
      check("stall_req_ready", Inst_Req_Ready === 1'b0, Inst_Req_Ready, 0);
    end
    @(posedge clk);
    #1;
    irdy_dir = 1'b1;
    drain();

    // Reset during a load wait drops the load, keeps stored data
    do_read(32'h8);
    #2;
    rst = 1'b1;
    dq.delete();
    @(negedge clk);
    check("midrst_mem_req_ready", Mem_Req_Ready === 1'b1, Mem_Req_Ready, 1);
    check("midrst_rd_valid", Read_data_Valid === 1'b0, Read_data_Valid, 0);
    check("midrst_read_data", Read_data === 32'd0, Read_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("postrst_mem_req_ready", Mem_Req_Ready === 1'b1, Mem_Req_Ready, 1);
    repeat (6) begin
      @(negedge clk);
      check("postrst_no_rd_valid", Read_data_Valid === 1'b0,
            Read_data_Valid, 0);
    end
    @(posedge clk);
    #1;
    do_read(32'h8);
    drain();

    // Address wrap modulo RAM depth
    do_write(32'h1004, 32'h0BADC0DE, 4'b1111, 0);
    do_read(32'h0004);
    do_fetch(32'h0004, BASE);
    drain();
    check("wrap_model", model[1] === 32'h0BADC0DE, model[1], 32'h0BADC0DE);

    // Fill data words 0..15 and fetch words 64..79
    for (int i = 0; i < 16; i++) begin
      do_write(32'(i * 4), $urandom, 4'b1111, 0);
      do_write(32'((64 + i) * 4), $urandom, 4'b1111, 0);
    end

    // Random concurrent traffic with random back-pressure
    rand_rdy = 1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          do_fetch(($urandom & 32'hFFFF_F000) |
                   32'((64 + $urandom_range(0, 15)) * 4) |
                   32'($urandom_range(0, 3)), -1);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          int          op;
          logic [31:0] a;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          op = $urandom_range(0, 9);
          a  = ($urandom & 32'hFFFF_F000) |
               32'($urandom_range(0, 15) * 4) |
               32'($urandom_range(0, 3));
          if (op < 4)
            do_write(a, $urandom, 4'($urandom_range(0, 15)), 0);
          else if (op < 8)
            do_read(a);
          else
            do_write(a, $urandom, 4'($urandom_range(0, 15)), 1);
        end
      end
    join
    drain();
    rand_rdy = 0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning number of word-address bits (RAM depth 2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter RESP_DELAY, default 2, meaning extra wait cycles between request acceptance and RAM read (0..15).
REQ-003 SHALL have port clk, input, 1, meaning single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port PC, input, 32, meaning instruction fetch byte address.
REQ-006 SHALL have port Inst_Req_Valid, input, 1, meaning fetch request valid.
REQ-007 SHALL have port Inst_Req_Ready, output, 1, meaning fetch request accepted.
REQ-008 SHALL have port Instruction, output, 32, meaning fetched word.
REQ-009 SHALL have port Inst_Valid, output, 1, meaning Instruction valid.
REQ-010 SHALL have port Inst_Ready, input, 1, meaning initiator takes Instruction.
REQ-011 SHALL have port Address, input, 32, meaning data byte address.
REQ-012 SHALL have ports MemWrite (input, 1, store request), Write_data (input, 32, store data), Write_strb (input, 4, byte enables) and MemRead (input, 1, load request).
REQ-013 SHALL have port Mem_Req_Ready, output, 1, meaning data request accepted.
REQ-014 SHALL have ports Read_data (output, 32, load word), Read_data_Valid (output, 1, Read_data valid) and Read_data_Ready (input, 1, initiator takes Read_data).

Function
REQ-015 SHALL hold one single-port 32-bit RAM indexed by addr[ADDR_WIDTH+1:2]; addr[1:0] and bits above ADDR_WIDTH+1 are ignored (wrap modulo depth).
REQ-016 SHALL run an instruction FSM with states I_IDLE, I_WAIT and I_RESP.
REQ-017 SHALL run an independent data FSM with states D_IDLE, D_WAIT and D_RESP.
REQ-018 SHALL assert Inst_Req_Ready only in I_IDLE.
REQ-019 SHALL, when Inst_Req_Valid and Inst_Req_Ready are both high, latch the PC word index, load an inst counter with RESP_DELAY, and move to I_WAIT.
REQ-020 SHALL in I_WAIT decrement the counter while it is nonzero; when it is 0 and the RAM is granted, register the RAM word into Instruction and move to I_RESP.
REQ-021 SHALL in I_RESP hold Inst_Valid=1 with Instruction stable, and return to I_IDLE in the cycle Inst_Ready=1.
REQ-022 SHALL assert Mem_Req_Ready only in D_IDLE.
REQ-023 SHALL, on MemWrite and Mem_Req_Ready, write the enabled bytes of Write_data in that same cycle and remain in D_IDLE; Write_strb=0000 leaves the RAM unchanged.
REQ-024 SHALL, on MemRead and Mem_Req_Ready with MemWrite low, latch the word index, load a data counter with RESP_DELAY, and move to D_WAIT.
REQ-025 SHALL give D_WAIT the same counter and grant rule as REQ-020, register the word into Read_data and move to D_RESP.
REQ-026 SHALL in D_RESP hold Read_data_Valid=1 with Read_data stable, and return to D_IDLE in the cycle Read_data_Ready=1.
REQ-027 SHALL, when MemWrite and MemRead are high together, perform the write only and produce no read response.
REQ-028 SHALL allow one RAM access per cycle, with priority data write > data read > instruction read; the losing instruction read stays in I_WAIT with counter 0 and retries the next cycle.
REQ-029 SHALL make a write accepted in cycle T visible to any RAM read performed in cycle T+1 or later.
REQ-030 SHALL produce, with no contention, Inst_Valid/Read_data_Valid first high in cycle T+2+RESP_DELAY, where T is the acceptance cycle.
REQ-031 SHALL ignore request inputs while the corresponding FSM is not idle.
REQ-032 SHALL treat an Inst_Ready or Read_data_Ready held high early as acceptance in the first valid cycle, giving a one-cycle response.

Reset
REQ-033 SHALL, on rst, immediately force I_IDLE and D_IDLE, clear both counters, and set Instruction=0, Read_data=0, Inst_Valid=0 and Read_data_Valid=0, with Inst_Req_Ready=1 and Mem_Req_Ready=1 after release.
REQ-034 SHALL abandon any in-flight request when rst is asserted mid-operation; a write already performed is kept.
REQ-035 SHALL not initialise RAM contents on reset.

Verification
REQ-036 Bench SHALL cover: write Address=0x10, data 0xDEADBEEF, strb 1111, then fetch PC=0x10 -> Instruction=0xDEADBEEF, Inst_Valid first high at T+4 (RESP_DELAY=2).
REQ-037 Bench SHALL cover: word 0x8 holds 0x11223344, store 0xAA at Address=0x9 with strb 0010, then load 0x8 -> Read_data=0x1122AA44.
REQ-038 Bench SHALL cover: fetch and load reach counter 0 in the same cycle -> Read_data_Valid rises one cycle before Inst_Valid, and both data values are correct.
REQ-039 Bench SHALL cover: Inst_Ready held low 5 cycles in I_RESP -> Inst_Valid and Instruction stay stable, Inst_Req_Ready=0 throughout.
REQ-040 Bench SHALL cover: rst pulsed in D_WAIT -> Read_data_Valid never asserts, Mem_Req_Ready=1 on the first edge after release.
REQ-041 Bench SHALL cover: ADDR_WIDTH=10, write Address=0x1004 -> data readable at Address=0x0004 (wrap).
